// File: rtl/mfp_clock_rate_controller.sv
// Programmable clock-enable generator with three divided rates, halt, software override and single-step.
// Define MFP_CLOCK_RATE_STEP_EN to build the single-step state, step_req synchronizer and edge detector.
module mfp_clock_rate_controller #(
    parameter int DIV_POW_FASTEST = 1,
    parameter int DIV_POW_MID     = 22,
    parameter int DIV_POW_SLOWEST = 26
) (
    input  logic       clki,
    input  logic       rst,
    input  logic       sel_lo,
    input  logic       sel_mid,
    input  logic       sw_we,
    input  logic [2:0] sw_data,
    input  logic       step_mode,
    input  logic       step_req,
    output logic       tick,
    output logic       clko,
    output logic [1:0] cur_rate,
    output logic       rate_pending
);

    localparam int W = DIV_POW_SLOWEST;
    localparam logic [W-1:0] ONES      = '1;
    localparam logic [W-1:0] TERM_FAST = ONES >> (W - DIV_POW_FASTEST);
    localparam logic [W-1:0] TERM_MID  = ONES >> (W - DIV_POW_MID);
    localparam logic [W-1:0] TERM_SLOW = ONES;

`ifdef MFP_CLOCK_RATE_STEP_EN
    typedef enum logic [1:0] {RUN, HALT, STEP} state_t;
`else
    typedef enum logic [1:0] {RUN, HALT} state_t;
`endif

    state_t       state, state_next;
    logic [W-1:0] cnt, cnt_next, term;
    logic [2:0]   ovr;
    logic [1:0]   req_rate, rate_next;
    logic         init, wrap, step_fire, tick_next;

    always_comb begin
        if (ovr[2])       req_rate = ovr[1:0];
        else if (sel_lo)  req_rate = 2'b10;
        else if (sel_mid) req_rate = 2'b01;
        else              req_rate = 2'b00;
    end

    assign rate_pending = (req_rate != cur_rate);

    always_comb begin
        case (cur_rate)
            2'b00:   term = TERM_FAST;
            2'b01:   term = TERM_MID;
            default: term = TERM_SLOW;
        endcase
    end

    assign wrap = (state == RUN) && (cnt == term);

`ifdef MFP_CLOCK_RATE_STEP_EN
    logic sync1, sync2, sync3, edge_q;

    // Edge is registered so a step tick lands 3 cycles after step_req is first sampled high.
    always_ff @(posedge clki) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= step_req;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    assign step_fire = (state == STEP) && edge_q;
`else
    logic unused_step;
    assign unused_step = step_mode ^ step_req;
    assign step_fire   = 1'b0;
`endif

    // The first cycle after reset applies the resolved request immediately and restarts the count.
    always_comb begin
        cnt_next  = cnt;
        rate_next = cur_rate;
        if (init) begin
            cnt_next  = '0;
            rate_next = req_rate;
        end else begin
            case (state)
                RUN: begin
                    if (wrap) begin
                        cnt_next  = '0;
                        rate_next = req_rate;
                    end else begin
                        cnt_next = cnt + W'(1);
                    end
                end
                HALT: begin
                    cnt_next  = '0;
                    rate_next = req_rate;
                end
`ifdef MFP_CLOCK_RATE_STEP_EN
                STEP: begin
                    rate_next = req_rate;
                    if (!step_mode) cnt_next = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clki) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = (rate_next == 2'b11) ? HALT : RUN;
`ifdef MFP_CLOCK_RATE_STEP_EN
        if (step_mode) state_next = STEP;
`endif
    end

    always_comb begin
        tick_next = (wrap && !init) || step_fire;
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            cnt      <= '0;
            ovr      <= '0;
            cur_rate <= 2'b00;
            tick     <= 1'b0;
            clko     <= 1'b0;
            init     <= 1'b1;
        end else begin
            cnt      <= cnt_next;
            cur_rate <= rate_next;
            tick     <= tick_next;
            clko     <= clko ^ tick_next;
            init     <= 1'b0;
            if (sw_we) ovr <= sw_data;
        end
    end

endmodule

// File: tb/tb_mfp_clock_rate_controller.sv
// Bench for mfp_clock_rate_controller with DIV_POW = 1/3/5: input table plus scoreboard of tick cycles.
module tb_mfp_clock_rate_controller;

    logic       clki = 1'b0;
    logic       rst = 1'b1;
    logic       sel_lo = 1'b0;
    logic       sel_mid = 1'b0;
    logic       sw_we = 1'b0;
    logic [2:0] sw_data = 3'b000;
    logic       step_mode = 1'b0;
    logic       step_req = 1'b0;
    logic       tick, clko, rate_pending;
    logic [1:0] cur_rate;

    mfp_clock_rate_controller #(
        .DIV_POW_FASTEST(1),
        .DIV_POW_MID(3),
        .DIV_POW_SLOWEST(5)
    ) dut (
        .clki(clki),
        .rst(rst),
        .sel_lo(sel_lo),
        .sel_mid(sel_mid),
        .sw_we(sw_we),
        .sw_data(sw_data),
        .step_mode(step_mode),
        .step_req(step_req),
        .tick(tick),
        .clko(clko),
        .cur_rate(cur_rate),
        .rate_pending(rate_pending)
    );

    always #5 clki = ~clki;

    typedef struct {
        int         off;
        logic       r, lo, mid, we;
        logic [2:0] data;
        logic       sm, sr;
        logic [1:0] rate;
        logic       pend;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   base;
    logic rst_q = 1'b1;
    logic sb_on = 1'b0;
    logic exp_clko = 1'b0;

    always @(posedge clki) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void add(input int off, input logic r, input logic lo, input logic mid,
                                input logic we, input logic [2:0] data, input logic sm,
                                input logic sr, input logic [1:0] rate, input logic pend);
        vec_t v;
        v.off = off; v.r = r; v.lo = lo; v.mid = mid; v.we = we; v.data = data;
        v.sm = sm; v.sr = sr; v.rate = rate; v.pend = pend;
        vecs.push_back(v);
    endfunction

    // Expected tick and clko per cycle come from the scheduled tick cycles and the bench's view of rst.
    always @(negedge clki) begin
        logic et;
        if (sb_on) begin
            et = 1'b0;
            if (rst_q) begin
                exp_clko = 1'b0;
            end else if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                et = 1'b1;
                void'(exp_q.pop_front());
                exp_clko = ~exp_clko;
            end
            chk("tick", {31'd0, tick}, {31'd0, et});
            chk("clko", {31'd0, clko}, {31'd0, exp_clko});
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int offs[$];
        //   off  rst lo mid we data   sm sr  rate   pend
        add(  0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 0);
        add(  1, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 0);
        add( 18, 0, 0, 1, 0, 3'b000, 0, 0, 2'b00, 1);
        add( 19, 0, 0, 1, 0, 3'b000, 0, 0, 2'b01, 0);
        add( 36, 0, 1, 1, 0, 3'b000, 0, 0, 2'b01, 1);
        add( 43, 0, 1, 1, 0, 3'b000, 0, 0, 2'b10, 0);
        add( 76, 0, 1, 1, 1, 3'b111, 0, 0, 2'b10, 0);
        add( 77, 0, 1, 1, 0, 3'b000, 0, 0, 2'b10, 1);
        add(107, 0, 1, 1, 0, 3'b000, 0, 0, 2'b11, 0);
        add(130, 0, 1, 1, 1, 3'b000, 0, 0, 2'b11, 0);
        add(131, 0, 1, 1, 0, 3'b000, 0, 0, 2'b11, 1);
        add(132, 0, 1, 1, 0, 3'b000, 0, 0, 2'b10, 0);
        add(165, 0, 0, 1, 0, 3'b000, 0, 0, 2'b10, 1);
        add(196, 0, 0, 1, 0, 3'b000, 0, 0, 2'b01, 0);
        add(197, 0, 1, 1, 0, 3'b000, 0, 0, 2'b01, 1);
        add(200, 0, 0, 0, 0, 3'b000, 0, 0, 2'b01, 1);
        add(203, 0, 0, 0, 0, 3'b000, 0, 0, 2'b01, 1);
        add(204, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 0);
        add(211, 0, 1, 0, 0, 3'b000, 0, 0, 2'b00, 1);
        add(212, 0, 1, 0, 0, 3'b000, 0, 0, 2'b10, 0);
        add(217, 1, 1, 0, 0, 3'b000, 0, 0, 2'b10, 0);
        add(218, 1, 1, 0, 0, 3'b000, 0, 0, 2'b00, 1);
        add(220, 0, 1, 0, 0, 3'b000, 0, 0, 2'b00, 1);
        add(221, 0, 1, 0, 0, 3'b000, 0, 0, 2'b10, 0);
        add(254, 0, 1, 0, 0, 3'b000, 0, 0, 2'b10, 0);
        add(286, 0, 1, 0, 0, 3'b000, 1, 0, 2'b10, 0);
        add(290, 0, 1, 0, 0, 3'b000, 1, 1, 2'b10, 0);
        add(294, 0, 1, 0, 0, 3'b000, 1, 0, 2'b10, 0);
        add(296, 0, 0, 0, 0, 3'b000, 1, 0, 2'b10, 1);
`ifdef MFP_CLOCK_RATE_STEP_EN
        add(297, 0, 0, 0, 0, 3'b000, 1, 0, 2'b00, 0);
        add(298, 0, 1, 0, 0, 3'b000, 1, 0, 2'b00, 1);
`else
        add(297, 0, 0, 0, 0, 3'b000, 1, 0, 2'b10, 1);
        add(298, 0, 1, 0, 0, 3'b000, 1, 0, 2'b10, 0);
`endif
        add(299, 0, 1, 0, 0, 3'b000, 1, 0, 2'b10, 0);
        add(300, 0, 1, 0, 0, 3'b000, 1, 1, 2'b10, 0);
        add(304, 0, 1, 0, 0, 3'b000, 1, 0, 2'b10, 0);
        add(310, 0, 1, 0, 0, 3'b000, 1, 1, 2'b10, 0);
        add(314, 0, 1, 0, 0, 3'b000, 1, 0, 2'b10, 0);
        add(320, 0, 1, 0, 0, 3'b000, 0, 0, 2'b10, 0);
        add(330, 0, 1, 0, 0, 3'b000, 0, 1, 2'b10, 0);
        add(334, 0, 1, 0, 0, 3'b000, 0, 0, 2'b10, 0);
        add(354, 0, 1, 0, 0, 3'b000, 0, 0, 2'b10, 0);

        offs = '{3, 5, 7, 9, 11, 13, 15, 17, 19, 27, 35, 43, 75, 107, 164, 196,
                 204, 206, 208, 210, 212, 253, 285};
`ifdef MFP_CLOCK_RATE_STEP_EN
        offs.push_back(294); offs.push_back(304); offs.push_back(314); offs.push_back(353);
`else
        offs.push_back(317); offs.push_back(349);
`endif

        // Reset hold: outputs quiet, request combinational even in reset.
        repeat (3) @(negedge clki);
        #1;
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_clko", {31'd0, clko}, 32'd0);
        chk("rst_rate", {30'd0, cur_rate}, 32'd0);
        chk("rst_pend", {31'd0, rate_pending}, 32'd0);
        sel_mid = 1'b1;
        #1;
        chk("rst_pend_mid", {31'd0, rate_pending}, 32'd1);
        @(negedge clki);
        #1;
        chk("rst_rate_held", {30'd0, cur_rate}, 32'd0);
        sel_mid = 1'b0;

        @(negedge clki);
        base = cyc;
        foreach (offs[i]) exp_q.push_back(base + offs[i]);
        sb_on = 1'b1;

        foreach (vecs[i]) begin
            while (cyc < base + vecs[i].off) @(negedge clki);
            rst = vecs[i].r; sel_lo = vecs[i].lo; sel_mid = vecs[i].mid;
            sw_we = vecs[i].we; sw_data = vecs[i].data;
            step_mode = vecs[i].sm; step_req = vecs[i].sr;
            #1;
            chk($sformatf("cur_rate@%0d", vecs[i].off), {30'd0, cur_rate}, {30'd0, vecs[i].rate});
            chk($sformatf("pending@%0d", vecs[i].off), {31'd0, rate_pending}, {31'd0, vecs[i].pend});
        end

        @(negedge clki);
        sb_on = 1'b0;
        chk("ticks_outstanding", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
